power_sequencer: RTL
====================

POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 5, meaning the number of supply rails sequenced, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of every delay counter.
REQ-003 SHALL have parameter RST_DELAY, default 500, meaning the cycles from extclk_en rising to sensor_reset_bar rising.
REQ-004 SHALL have parameter INIT_DELAY, default 500, meaning the cycles from sensor_reset_bar rising to done.
REQ-005 SHALL have parameter PG_TIMEOUT, default 1000, meaning the maximum cycles to wait for a rail's power-good.
REQ-006 SHALL have ports: clock  in  1  sole clock; all logic on the rising edge.
REQ-007 SHALL have ports: reset_bar  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: start  in  1  level; request power-up from IDLE.
REQ-009 SHALL have ports: stop  in  1  level; request power-down.
REQ-010 SHALL have ports: clear_fault  in  1  pulse; leave FAULT.
REQ-011 SHALL have ports: step_delay  in  CNT_W  inter-rail spacing in cycles, sampled on leaving IDLE.
REQ-012 SHALL have ports: pg  in  NUM_RAILS  per-rail power-good.
REQ-013 SHALL have ports: rail_en  out  NUM_RAILS  rail enables; bit 0 powers first.
REQ-014 SHALL have ports: extclk_en  out  1  sensor external-clock gate enable; the block never outputs a gated clock.
REQ-015 SHALL have ports: sensor_reset_bar  out  1  sensor reset, active-low.
REQ-016 SHALL have ports: done  out  1  one-cycle pulse when the sensor is ready.
REQ-017 SHALL have ports: ready  out  1  level, high in READY.
REQ-018 SHALL have ports: busy  out  1  high in every state except IDLE, READY and FAULT.
REQ-019 SHALL have ports: fault  out  1  high in FAULT.
REQ-020 SHALL have ports: fault_rail  out  4  index of the rail that timed out; holds its value until the next fault.

Function
REQ-021 SHALL implement the states IDLE, RAMP_UP, CLK_ON, RELEASE, READY, RAMP_DOWN and FAULT, with all outputs registered.
REQ-022 SHALL, in IDLE with start=1 and stop=0, latch step_delay and enter RAMP_UP; rail_en[0] SHALL rise on the following edge.
REQ-023 SHALL, in RAMP_UP, raise rail_en[k+1] exactly D cycles after rail_en[k]; D is the latched step_delay, with 0 treated as 1.
REQ-024 SHALL enter CLK_ON D cycles after the last rail rises, and raise extclk_en at that point.
REQ-025 SHALL raise sensor_reset_bar RST_DELAY cycles after extclk_en, then enter RELEASE.
REQ-026 SHALL, INIT_DELAY cycles after sensor_reset_bar rises, pulse done for one cycle and enter READY.
REQ-027 SHALL, on stop=1 in RAMP_UP, CLK_ON, RELEASE or READY, enter RAMP_DOWN; sensor_reset_bar and extclk_en SHALL fall on the next edge.
REQ-028 SHALL, in RAMP_DOWN, drop enabled rails in reverse index order, the first one cycle after entry and the rest D cycles apart, then enter IDLE.
REQ-029 SHALL ignore start while in RAMP_DOWN and FAULT; stop SHALL win over a simultaneous start in IDLE.
REQ-030 SHALL ignore start held high through READY, with no re-sequencing; re-sequencing requires a return to IDLE.
REQ-031 SHALL, in FAULT, hold all rail_en bits, extclk_en and sensor_reset_bar low; clear_fault SHALL enter IDLE.
REQ-032 SHALL compare counters against terminal value minus one, so each delay is exact; counters SHALL not wrap, since terminals never exceed 2^CNT_W-1.

Reset
REQ-033 SHALL, on reset_bar low, immediately place the block in IDLE and drive every output to 0, including fault_rail.
REQ-034 SHALL, when reset is asserted mid-sequence, drop all rails at once, with no reverse sequencing.

Configuration
REQ-035 SHALL, with PGOOD_CHECK_EN defined, require that after rail_en[k] rises, pg[k] goes high within PG_TIMEOUT cycles; otherwise the block SHALL enter FAULT with fault_rail=k.
REQ-036 SHALL, with PGOOD_CHECK_EN defined, start the D spacing of REQ-023 when pg[k] is seen; any pg[j] falling for an enabled rail in CLK_ON, RELEASE or READY SHALL cause FAULT.
REQ-037 SHALL, without PGOOD_CHECK_EN, ignore pg, sequence purely by time, and hold fault and fault_rail at 0.

Structure
REQ-038 SHALL place the state enum typedef and the default delay constants in package power_seq_pkg.
REQ-039 SHALL use sub-module delay_counter: a loadable CNT_W-bit counter with clear, enable and a terminal-reached flag, instantiated once and shared by all states.

Verification
REQ-040 SHALL cover: NUM_RAILS=5, step_delay=10, start pulse -> rail_en rises at cycles 1, 11, 21, 31, 41; extclk_en at 51; sensor_reset_bar at 51+RST_DELAY; done at 51+RST_DELAY+INIT_DELAY.
REQ-041 SHALL cover: step_delay=0 -> consecutive rails 1 cycle apart.
REQ-042 SHALL cover: stop in READY, step_delay=4 -> extclk_en and sensor_reset_bar low next cycle; rails 4, 3, 2, 1, 0 drop at cycles 1, 5, 9, 13, 17 after stop; then IDLE.
REQ-043 SHALL cover: stop after 3 rails enabled -> only rails 2, 1, 0 drop, in reverse order.
REQ-044 SHALL cover, with PGOOD_CHECK_EN and PG_TIMEOUT=20: pg[2] held low -> FAULT 20 cycles after rail_en[2] rises, fault_rail=2, all rails low; clear_fault -> IDLE.
REQ-045 SHALL cover: reset_bar low mid-RAMP_UP -> all outputs 0 asynchronously; start after reset release -> normal sequence.

Source files
------------

// File: rtl/power_seq_pkg.sv
// Shared types and default timing for the sensor power sequencer.
package power_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAMP_UP,
      ST_CLK_ON,
      ST_RELEASE,
      ST_READY,
      ST_RAMP_DOWN,
      ST_FAULT
   } state_t;

   localparam int unsigned DEF_NUM_RAILS  = 5;
   localparam int unsigned DEF_CNT_W      = 32;
   localparam int unsigned DEF_RST_DELAY  = 500;
   localparam int unsigned DEF_INIT_DELAY = 500;
   localparam int unsigned DEF_PG_TIMEOUT = 1000;

   // Counters fire at terminal-1 so a delay of N cycles is exactly N edges;
   // a zero delay collapses to one cycle.
   function automatic int unsigned term_m1(input int unsigned v);
      return (v == 0) ? 0 : v - 1;
   endfunction

endpackage

// File: rtl/power_sequencer_delay_counter.sv
// Loadable up-counter with clear, enable and a terminal-match flag.
// Saturates at all-ones instead of wrapping.
module delay_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_bar,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             enable,
   input  logic [CNT_W-1:0] terminal,
   output logic [CNT_W-1:0] count,
   output logic             at_term
);

   // Load beats clear beats count; hold at all-ones rather than wrap.
   always_ff @(posedge clock or negedge reset_bar) begin
      if (!reset_bar)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + 1'b1;
   end

   assign at_term = (count == terminal);

endmodule

// File: rtl/power_sequencer.sv
// Power-up / power-down sequencer for an image sensor: staggers rail enables,
// gates the sensor external clock, then releases sensor reset.
// Optional build macro PGOOD_CHECK_EN: per-rail power-good supervision with
// timeout and drop detection; without it pg is ignored and fault stays 0.
module power_sequencer
   import power_seq_pkg::*;
#(
   parameter int NUM_RAILS  = DEF_NUM_RAILS,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int RST_DELAY  = DEF_RST_DELAY,
   parameter int INIT_DELAY = DEF_INIT_DELAY,
   parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
   input  logic                 clock,
   input  logic                 reset_bar,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 clear_fault,
   input  logic [CNT_W-1:0]     step_delay,
   input  logic [NUM_RAILS-1:0] pg,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic                 extclk_en,
   output logic                 sensor_reset_bar,
   output logic                 done,
   output logic                 ready,
   output logic                 busy,
   output logic                 fault,
   output logic [3:0]           fault_rail
);

   localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(term_m1(RST_DELAY));
   localparam logic [CNT_W-1:0] INIT_M1 = CNT_W'(term_m1(INIT_DELAY));
   localparam logic [CNT_W-1:0] PG_M1   = CNT_W'(term_m1(PG_TIMEOUT));

   state_t               state;
   logic [CNT_W-1:0]     d_m1;       // latched spacing minus one
   logic [CNT_W-1:0]     step_m1;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     cnt_term;
   logic [CNT_W-1:0]     cnt_load_val;
   logic                 cnt_load, cnt_clear, cnt_en, hit;
   logic                 start_req, stop_req;
   logic                 pg_wait;    // last raised rail still waiting for pg
   logic                 pg_seen;
   logic                 fault_req;
   logic [3:0]           fault_idx;
   logic [NUM_RAILS-1:0] top_rail;   // highest enabled rail (rails fill from bit 0)

   assign step_m1   = (step_delay == '0) ? '0 : step_delay - 1'b1;
   assign start_req = (state == ST_IDLE) && start && !stop;
   assign stop_req  = stop && (state inside {ST_RAMP_UP, ST_CLK_ON, ST_RELEASE, ST_READY});
   assign top_rail  = rail_en & ~(rail_en >> 1);

   // Preloading D-1 on entry to either ramp makes the first rail step one cycle later.
   assign cnt_load     = start_req || stop_req;
   assign cnt_load_val = (state == ST_IDLE) ? step_m1 : d_m1;
   assign cnt_clear    = hit || pg_seen;
   assign cnt_en       = state inside {ST_RAMP_UP, ST_CLK_ON, ST_RELEASE, ST_RAMP_DOWN};

   // Terminal for whichever delay the current state is timing.
   always_comb begin
      cnt_term = '0;
      case (state)
         ST_RAMP_UP:   cnt_term = pg_wait ? PG_M1 : d_m1;
         ST_CLK_ON:    cnt_term = RST_M1;
         ST_RELEASE:   cnt_term = INIT_M1;
         ST_RAMP_DOWN: cnt_term = d_m1;
         default:      cnt_term = '0;
      endcase
   end

   delay_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock      (clock),
      .reset_bar  (reset_bar),
      .clear      (cnt_clear),
      .load       (cnt_load),
      .load_value (cnt_load_val),
      .enable     (cnt_en),
      .terminal   (cnt_term),
      .count      (count),
      .at_term    (hit)
   );

`ifdef PGOOD_CHECK_EN
   function automatic logic [3:0] lowest_idx(input logic [NUM_RAILS-1:0] v);
      lowest_idx = '0;
      for (int i = NUM_RAILS - 1; i >= 0; i--)
         if (v[i]) lowest_idx = 4'(i);
   endfunction

   assign pg_seen = (state == ST_RAMP_UP) && pg_wait && |(top_rail & pg);

   // Fault on pg timeout during ramp-up, or any enabled rail losing pg once up.
   always_comb begin
      fault_req = 1'b0;
      fault_idx = '0;
      if ((state == ST_RAMP_UP) && pg_wait && !pg_seen && hit) begin
         fault_req = 1'b1;
         fault_idx = 4'($countones(rail_en) - 1);
      end else if ((state inside {ST_CLK_ON, ST_RELEASE, ST_READY}) && |(rail_en & ~pg)) begin
         fault_req = 1'b1;
         fault_idx = lowest_idx(rail_en & ~pg);
      end
   end
`else
   logic unused_pg;
   assign unused_pg = ^pg;
   assign pg_seen   = 1'b0;
   assign fault_req = 1'b0;
   assign fault_idx = '0;
`endif

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clock or negedge reset_bar) begin
      if (!reset_bar) begin
         state            <= ST_IDLE;
         d_m1             <= '0;
         pg_wait          <= 1'b0;
         rail_en          <= '0;
         extclk_en        <= 1'b0;
         sensor_reset_bar <= 1'b0;
         done             <= 1'b0;
         ready            <= 1'b0;
         busy             <= 1'b0;
         fault            <= 1'b0;
         fault_rail       <= '0;
      end else begin
         done <= 1'b0;
         if (fault_req) begin
            state            <= ST_FAULT;
            pg_wait          <= 1'b0;
            rail_en          <= '0;
            extclk_en        <= 1'b0;
            sensor_reset_bar <= 1'b0;
            ready            <= 1'b0;
            busy             <= 1'b0;
            fault            <= 1'b1;
            fault_rail       <= fault_idx;
         end else if (stop_req) begin
            state            <= ST_RAMP_DOWN;
            pg_wait          <= 1'b0;
            extclk_en        <= 1'b0;
            sensor_reset_bar <= 1'b0;
            ready            <= 1'b0;
            busy             <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_req) begin
                     state <= ST_RAMP_UP;
                     d_m1  <= step_m1;
                     busy  <= 1'b1;
                  end
               end
               ST_RAMP_UP: begin
                  if (pg_wait) begin
                     if (pg_seen) pg_wait <= 1'b0;
                  end else if (hit) begin
                     if (&rail_en) begin
                        state     <= ST_CLK_ON;
                        extclk_en <= 1'b1;
                     end else begin
                        rail_en <= (rail_en << 1) | NUM_RAILS'(1);
`ifdef PGOOD_CHECK_EN
                        pg_wait <= 1'b1;
`endif
                     end
                  end
               end
               ST_CLK_ON: begin
                  if (hit) begin
                     state            <= ST_RELEASE;
                     sensor_reset_bar <= 1'b1;
                  end
               end
               ST_RELEASE: begin
                  if (hit) begin
                     state <= ST_READY;
                     done  <= 1'b1;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
               ST_READY: ;
               ST_RAMP_DOWN: begin
                  if (hit) begin
                     rail_en <= rail_en >> 1;
                     if ((rail_en >> 1) == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
               ST_FAULT: begin
                  if (clear_fault) begin
                     state <= ST_IDLE;
                     fault <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
